// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the cpu run controller.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CPU_RST,
        RUN,
        DONE
    } state_t;

    localparam int RST_HOLD_CYCLES = 2;
    localparam int RST_CNT_W       = 2;

endpackage

// File: rtl/imem_loader.sv
// Program streaming port: word index, overflow flag and a registered
// instruction-memory write port.
module imem_loader #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          accept_i,
    input  logic          first_i,
    input  logic          last_i,
    input  logic [DW-1:0] data_i,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [DW-1:0] wdata_o,
    output logic          err_o
);

    localparam int IW = $clog2(DEPTH + 1);

    logic [IW-1:0] idx_q, idx_d, eff_idx;
    logic          in_range;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          err_q, err_d;

    always_comb begin
        eff_idx  = first_i ? '0 : idx_q;
        in_range = eff_idx < IW'(DEPTH);
        idx_d    = idx_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        err_d    = first_i ? 1'b0 : err_q;
        if (accept_i) begin
            if (in_range) begin
                we_d    = 1'b1;
                waddr_d = AW'(eff_idx) << 2;
                wdata_d = data_i;
                idx_d   = eff_idx + 1'b1;
            end else begin
                // past capacity: swallow the word so the host never stalls
                err_d = 1'b1;
                idx_d = eff_idx;
            end
            if (last_i) idx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign err_o   = err_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller around the single-cycle RV32 cpu: program load,
// reset hold, free-run or single-step, completion detect, a0 capture.
module cpu_run_ctrl import cpu_ctrl_pkg::*; #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int IMEM_DEPTH    = 256,
    parameter int CYC_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    input  logic                     start,
    input  logic                     single_step,
    input  logic                     step,
    input  logic                     halt_req,
    input  logic [CYC_WIDTH-1:0]     run_cycles,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0]    a0,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_waddr,
    output logic [DATA_WIDTH-1:0]    imem_wdata,
    output logic                     cpu_rst,
    output logic                     cpu_en,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [CYC_WIDTH-1:0]     cycle_count,
    output logic                     err_overflow
);

    state_t                   state_q, state_d;
    logic [RST_CNT_W-1:0]     rst_cnt_q;
    logic [CYC_WIDTH-1:0]     cyc_q;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic                     prev_en_q;
    logic [DATA_WIDTH-1:0]    result_q;
    logic                     accept, first, limit_hit, loop_hit;

    assign accept    = load_valid & load_ready;
    assign first     = accept & ((state_q == IDLE) | (state_q == DONE));
    assign limit_hit = (run_cycles != '0) && (cyc_q >= run_cycles);
    // a cpu that jumps to itself leaves pc unchanged across an enabled cycle
    assign loop_hit  = prev_en_q && (pc == pc_q);

    always_comb begin
        state_d    = state_q;
        cpu_rst    = 1'b0;
        cpu_en     = 1'b0;
        load_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                cpu_rst    = (state_q == IDLE);
                done       = (state_q == DONE);
                load_ready = 1'b1;
                if (accept)
                    state_d = load_last ? CPU_RST : LOAD;
                else if (start)
                    state_d = CPU_RST;
            end
            LOAD: begin
                cpu_rst    = 1'b1;
                load_ready = 1'b1;
                if (accept && load_last) state_d = CPU_RST;
            end
            CPU_RST: begin
                cpu_rst = 1'b1;
                if (rst_cnt_q == RST_CNT_W'(RST_HOLD_CYCLES - 1))
                    state_d = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                cpu_en = (single_step ? step : 1'b1)
                         & ~halt_req & ~limit_hit;
                if (halt_req || limit_hit || loop_hit)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rst_cnt_q <= '0;
            cyc_q     <= '0;
            pc_q      <= '0;
            prev_en_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc;
            prev_en_q <= cpu_en;
            if (state_q == CPU_RST) rst_cnt_q <= rst_cnt_q + 1'b1;
            else                    rst_cnt_q <= '0;
            if (state_q == CPU_RST)          cyc_q <= '0;
            else if (cpu_en && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
            if (state_d == DONE && state_q != DONE) result_q <= a0;
        end
    end

    assign result      = result_q;
    assign cycle_count = cyc_q;

    imem_loader #(
        .AW    (ADDRESS_WIDTH),
        .DW    (DATA_WIDTH),
        .DEPTH (IMEM_DEPTH)
    ) u_loader (
        .clk      (clk),
        .rst      (rst),
        .accept_i (accept),
        .first_i  (first),
        .last_i   (load_last),
        .data_i   (load_data),
        .we_o     (imem_we),
        .waddr_o  (imem_waddr),
        .wdata_o  (imem_wdata),
        .err_o    (err_overflow)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl; a tiny pc/a0 model stands in for the cpu.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        start = 1'b0;
    logic        single_step = 1'b0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;
    logic [15:0] run_cycles = '0;
    logic [31:0] pc = '0;
    logic [31:0] a0 = 32'd5;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst, cpu_en, busy, done;
    logic [31:0] result;
    logic [15:0] cycle_count;
    logic        err_overflow;

    logic loop_mode = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .IMEM_DEPTH    (4),
        .CYC_WIDTH     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .start        (start),
        .single_step  (single_step),
        .step         (step),
        .halt_req     (halt_req),
        .run_cycles   (run_cycles),
        .pc           (pc),
        .a0           (a0),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .cpu_en       (cpu_en),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .cycle_count  (cycle_count),
        .err_overflow (err_overflow)
    );

    // cpu stand-in: pc steps by 4, optionally parking on a self-jump at 0x8
    always @(posedge clk) begin
        if (cpu_rst)
            pc <= '0;
        else if (cpu_en)
            pc <= (loop_mode && pc == 32'h8) ? 32'h8 : pc + 32'd4;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        checks++;
        if ({cpu_rst, cpu_en, imem_we, load_ready, busy, done, err_overflow}
            !== 7'b1001000) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 1001000",
                {cpu_rst, cpu_en, imem_we, load_ready, busy, done, err_overflow});
        end
        checks++;
        if ({imem_waddr, imem_wdata, result, cycle_count} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0",
                imem_waddr, imem_wdata, result, cycle_count);
        end
        @(negedge clk);
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_load();
        load_valid = 1'b1;
        load_data  = 32'h0000_0013;
        #1;
        checks++;
        if ({load_ready, cpu_rst} !== 2'b11) begin
            errors++;
            $display("FAIL idle_ready got %b exp 11", {load_ready, cpu_rst});
        end
        cyc();
        checks++;
        if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 32'h0, 32'h13}) begin
            errors++;
            $display("FAIL wr0 got %b %h %h exp 1 0 13", imem_we, imem_waddr, imem_wdata);
        end
        load_data = 32'h0000_0293;
        cyc();
        checks++;
        if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 32'h4, 32'h293}) begin
            errors++;
            $display("FAIL wr1 got %b %h %h exp 1 4 293", imem_we, imem_waddr, imem_wdata);
        end
        load_data = 32'h0000_006f;
        load_last = 1'b1;
        cyc();
        checks++;
        if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 32'h8, 32'h6f}) begin
            errors++;
            $display("FAIL wr2 got %b %h %h exp 1 8 6f", imem_we, imem_waddr, imem_wdata);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        #1;
        checks++;
        if ({cpu_rst, load_ready, busy} !== 3'b100) begin
            errors++;
            $display("FAIL rst_hold1 got %b exp 100", {cpu_rst, load_ready, busy});
        end
        cyc();
        checks++;
        if ({imem_we, cpu_rst, load_ready, busy} !== 4'b0100) begin
            errors++;
            $display("FAIL rst_hold2 got %b exp 0100",
                {imem_we, cpu_rst, load_ready, busy});
        end
        cyc();
        checks++;
        if ({cpu_rst, busy, cpu_en} !== 3'b011) begin
            errors++;
            $display("FAIL run_entry got %b exp 011", {cpu_rst, busy, cpu_en});
        end
    endtask

    task automatic test_self_loop();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL early_done cyc %0d got %b exp 0", i, done);
            end
            cyc();
        end
        checks++;
        if ({done, busy, cpu_en} !== 3'b100) begin
            errors++;
            $display("FAIL loop_done got %b exp 100", {done, busy, cpu_en});
        end
        checks++;
        if (result !== 32'd5) begin
            errors++;
            $display("FAIL loop_result got %0d exp 5", result);
        end
        a0 = 32'd7;
        cyc();
        checks++;
        if (result !== 32'd5) begin
            errors++;
            $display("FAIL result_hold got %0d exp 5", result);
        end
    endtask

    task automatic test_run_limit();
        int  en_cnt;
        logic found;
        loop_mode  = 1'b0;
        run_cycles = 16'd10;
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if ({cpu_rst, done, busy} !== 3'b100) begin
            errors++;
            $display("FAIL rerun_rst got %b exp 100", {cpu_rst, done, busy});
        end
        cyc();
        checks++;
        if (cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clear got %0d exp 0", cycle_count);
        end
        cyc();
        en_cnt = 0;
        found  = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done === 1'b1) found = 1'b1;
            else begin
                if (cpu_en === 1'b1) en_cnt++;
                cyc();
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL limit_timeout got done=0 exp done=1");
        end
        checks++;
        if (en_cnt != 10) begin
            errors++;
            $display("FAIL limit_pulses got %0d exp 10", en_cnt);
        end
        checks++;
        if (cycle_count !== 16'd10) begin
            errors++;
            $display("FAIL limit_count got %0d exp 10", cycle_count);
        end
    endtask

    task automatic test_single_step();
        int en_cnt;
        run_cycles  = '0;
        single_step = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step = (i == 2 || i == 5 || i == 6);
            #1;
            if (cpu_en === 1'b1) en_cnt++;
            cyc();
        end
        step = 1'b0;
        checks++;
        if (en_cnt != 3) begin
            errors++;
            $display("FAIL step_pulses got %0d exp 3", en_cnt);
        end
        checks++;
        if ({busy, cycle_count} !== {1'b1, 16'd3}) begin
            errors++;
            $display("FAIL step_count got %b %0d exp 1 3", busy, cycle_count);
        end
        halt_req = 1'b1;
        step     = 1'b1;
        #1;
        checks++;
        if (cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_en got %b exp 0", cpu_en);
        end
        cyc();
        halt_req = 1'b0;
        step     = 1'b0;
        checks++;
        if ({done, busy, cycle_count} !== {2'b10, 16'd3}) begin
            errors++;
            $display("FAIL halt_done got %b %b %0d exp 1 0 3", done, busy, cycle_count);
        end
    endtask

    task automatic test_overflow();
        int we_cnt;
        single_step = 1'b0;
        we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h100 + i;
            load_last  = (i == 5);
            #1;
            if (i > 0 && imem_we === 1'b1) we_cnt++;
            if (i == 4) begin
                checks++;
                if ({imem_waddr, imem_wdata} !== {32'hc, 32'h103}) begin
                    errors++;
                    $display("FAIL wr3 got %h %h exp c 103", imem_waddr, imem_wdata);
                end
            end
            cyc();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        #1;
        if (imem_we === 1'b1) we_cnt++;
        checks++;
        if (we_cnt != 4) begin
            errors++;
            $display("FAIL ovf_writes got %0d exp 4", we_cnt);
        end
        checks++;
        if ({err_overflow, cpu_rst, load_ready} !== 3'b110) begin
            errors++;
            $display("FAIL ovf_flag got %b exp 110", {err_overflow, cpu_rst, load_ready});
        end
        cyc();
        cyc();
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        checks++;
        if ({done, err_overflow} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_sticky got %b exp 11", {done, err_overflow});
        end
        load_valid = 1'b1;
        load_data  = 32'h55;
        load_last  = 1'b1;
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
        checks++;
        if ({err_overflow, imem_we, imem_waddr, imem_wdata}
            !== {2'b01, 32'h0, 32'h55}) begin
            errors++;
            $display("FAIL reload got %b %b %h %h exp 0 1 0 55",
                err_overflow, imem_we, imem_waddr, imem_wdata);
        end
    endtask

    task automatic test_async_reset();
        cyc();
        cyc();
        cyc();
        cyc();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({cpu_rst, cpu_en, busy, done, load_ready, imem_we} !== 6'b100010) begin
            errors++;
            $display("FAIL arst_ctl got %b exp 100010",
                {cpu_rst, cpu_en, busy, done, load_ready, imem_we});
        end
        checks++;
        if ({cycle_count, result, imem_wdata} !== '0) begin
            errors++;
            $display("FAIL arst_data got %0d %h %h exp 0",
                cycle_count, result, imem_wdata);
        end
        #3;
        rst = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if ({cpu_rst, busy} !== 2'b10) begin
            errors++;
            $display("FAIL arst_rerun1 got %b exp 10", {cpu_rst, busy});
        end
        cyc();
        checks++;
        if ({cpu_rst, busy} !== 2'b10) begin
            errors++;
            $display("FAIL arst_rerun2 got %b exp 10", {cpu_rst, busy});
        end
        cyc();
        checks++;
        if ({cpu_rst, busy} !== 2'b01) begin
            errors++;
            $display("FAIL arst_run got %b exp 01", {cpu_rst, busy});
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_self_loop();
        test_run_limit();
        test_single_step();
        test_overflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
